// File: rtl/mips_mem_responder.sv
// mips_mem_responder
// Memory-side responder for the MIPS32 pipeline. A unified word-addressed
// instruction/data store sits behind two valid/ready request channels:
//   I : instruction fetch (read-only)
//   D : load/store
// The two channels share one storage port. Only one access is outstanding
// at a time, and each access has a fixed latency of RD_LATENCY edges from
// acceptance to a one-cycle response pulse.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   i_req_valid/addr, i_req_ready   fetch request channel
//   i_rsp_valid/data                fetch response pulse and instruction word
//   d_req_valid/we/addr/wdata       load/store request channel
//   d_req_ready                     data request accepted when valid&&ready
//   d_rsp_valid/data                load data or store acknowledge (echoes wdata)
//   busy                            an access is outstanding
module mips_mem_responder #(
  parameter int ADDR_W     = 10,
  parameter int RD_LATENCY = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_rsp_valid,
  output logic [31:0]       i_rsp_data,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [31:0]       d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [3:0]  starve_reg, starve_next;
  logic        gnt_d_reg, gnt_d_next;      // which port owns the outstanding access
  logic        i_rsp_valid_reg, i_rsp_valid_next;
  logic        d_rsp_valid_reg, d_rsp_valid_next;
  logic [31:0] i_rsp_data_reg, d_rsp_data_reg;
  logic [31:0] hold_reg;                   // word captured at the accept edge

  logic [31:0] mem [DEPTH];

  logic starve_full, grant_d, grant_i, can_accept, i_acc, d_acc, accept;

  // D wins contested cycles unless fetch has already lost STARVE_MAX in a row.
  assign starve_full = (starve_reg == 4'(STARVE_MAX));
  assign grant_d     = d_req_valid && !(i_req_valid && starve_full);
  assign grant_i     = i_req_valid && !grant_d;

  // Ready is gated by rst_n so nothing can be accepted while reset is held.
  assign can_accept  = (state_reg == IDLE) && rst_n;
  assign i_req_ready = can_accept && grant_i;
  assign d_req_ready = can_accept && grant_d;
  assign i_acc       = i_req_valid && i_req_ready;
  assign d_acc       = d_req_valid && d_req_ready;
  assign accept      = i_acc || d_acc;

  assign busy        = (state_reg != IDLE);
  assign i_rsp_valid = i_rsp_valid_reg;
  assign d_rsp_valid = d_rsp_valid_reg;
  assign i_rsp_data  = i_rsp_data_reg;
  assign d_rsp_data  = d_rsp_data_reg;

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    starve_next      = starve_reg;
    gnt_d_next       = gnt_d_reg;
    i_rsp_valid_next = 1'b0;
    d_rsp_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = BUSY;
          // The accept edge counts as the first of RD_LATENCY edges.
          cnt_next   = 4'(RD_LATENCY - 1);
          gnt_d_next = d_acc;
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
          if (gnt_d_reg) d_rsp_valid_next = 1'b1;
          else           i_rsp_valid_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Starvation counter tracks only contested D wins.
    if (i_acc) begin
      starve_next = 4'd0;
    end else if (d_acc) begin
      if (!i_req_valid)     starve_next = 4'd0;
      else if (!starve_full) starve_next = starve_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      starve_reg      <= 4'd0;
      gnt_d_reg       <= 1'b0;
      i_rsp_valid_reg <= 1'b0;
      d_rsp_valid_reg <= 1'b0;
      i_rsp_data_reg  <= 32'd0;
      d_rsp_data_reg  <= 32'd0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      starve_reg      <= starve_next;
      gnt_d_reg       <= gnt_d_next;
      i_rsp_valid_reg <= i_rsp_valid_next;
      d_rsp_valid_reg <= d_rsp_valid_next;
      // Response data holds between pulses.
      if (i_rsp_valid_next) i_rsp_data_reg <= hold_reg;
      if (d_rsp_valid_next) d_rsp_data_reg <= hold_reg;
    end
  end

  // Storage port: store commits and the read word is captured at the accept
  // edge, so a response in flight is immune to later writes. A store's
  // response echoes the written word.
  always_ff @(posedge clk) begin
    if (d_acc && d_req_we) mem[d_req_addr] <= d_req_wdata;
    if (accept) begin
      if (d_acc) hold_reg <= d_req_we ? d_req_wdata : mem[d_req_addr];
      else       hold_reg <= mem[i_req_addr];
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
module tb_mips_mem_responder;

  localparam int ADDR_W = 10;
  localparam int L      = 2;
  localparam int SMAX   = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_req_valid;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_ready;
  logic              i_rsp_valid;
  logic [31:0]       i_rsp_data;
  logic              d_req_valid;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_req_addr;
  logic [31:0]       d_req_wdata;
  logic              d_req_ready;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;
  logic              busy;

  int checks = 0;
  int errors = 0;
  time last_rsp_t;

  mips_mem_responder #(.ADDR_W(ADDR_W), .RD_LATENCY(L), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the response cycle with
  // the request dropped, so a following call presents back-to-back.
  task automatic access(input bit is_d, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, input string tag);
    if (is_d) begin
      d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata;
    end else begin
      i_req_valid = 1'b1; i_req_addr = addr;
    end
    #1;
    chk({tag, ":ready"}, is_d ? d_req_ready : i_req_ready, 1);
    chk({tag, ":other_ready"}, is_d ? i_req_ready : d_req_ready, 0);
    @(posedge clk);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      chk({tag, ":busy"}, busy, 1);
      chk({tag, ":early_rsp"}, is_d ? d_rsp_valid : i_rsp_valid, 0);
      chk({tag, ":ready_in_busy"}, is_d ? d_req_ready : i_req_ready, 0);
    end
    @(negedge clk);
    last_rsp_t = $time;
    chk({tag, ":rsp_valid"}, is_d ? d_rsp_valid : i_rsp_valid, 1);
    chk({tag, ":other_rsp"}, is_d ? i_rsp_valid : d_rsp_valid, 0);
    chk({tag, ":rsp_data"}, is_d ? d_rsp_data : i_rsp_data, exp);
    chk({tag, ":busy_rsp"}, busy, 0);
    $display("txn %s port=%s we=%0d addr=%h rsp=%h t=%0t", tag, is_d ? "D" : "I",
             we, addr, is_d ? d_rsp_data : i_rsp_data, $time);
    if (is_d) d_req_valid = 1'b0;
    else      i_req_valid = 1'b0;
  endtask

  initial begin
    time t1, t2, t3;
    bit  got [10];
    bit  exp_g [10];
    int  n;
    logic ir, dr;

    // ---- reset state, requests offered during reset must not be taken
    rst_n = 1'b0;
    i_req_valid = 1'b1; i_req_addr = '0;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = '0; d_req_wdata = 32'hFFFF_FFFF;
    @(negedge clk); @(negedge clk);
    chk("rst:i_ready", i_req_ready, 0);
    chk("rst:d_ready", d_req_ready, 0);
    chk("rst:busy", busy, 0);
    chk("rst:i_rsp_valid", i_rsp_valid, 0);
    chk("rst:d_rsp_valid", d_rsp_valid, 0);
    chk("rst:i_rsp_data", i_rsp_data, 0);
    chk("rst:d_rsp_data", d_rsp_data, 0);
    i_req_valid = 1'b0; d_req_valid = 1'b0; d_req_we = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst:busy", busy, 0);

    // ---- store then load, read-after-write
    access(1, 1, 10'h005, 32'hDEADBEEF, 32'hDEADBEEF, "st5");
    access(1, 0, 10'h005, 32'h0, 32'hDEADBEEF, "ld5");

    // ---- fetch latency
    access(1, 1, 10'h010, 32'h0C000001, 32'h0C000001, "st10");
    access(0, 0, 10'h010, 32'h0, 32'h0C000001, "if10");

    // ---- wrap: top address and address 0 are distinct words
    access(1, 1, 10'h000, 32'hA5A5A5A5, 32'hA5A5A5A5, "st0");
    access(1, 1, 10'h3FF, 32'h00001234, 32'h00001234, "st3ff");
    access(1, 0, 10'h3FF, 32'h0, 32'h00001234, "ld3ff");
    access(1, 0, 10'h000, 32'h0, 32'hA5A5A5A5, "ld0");

    // ---- back-to-back throughput
    access(0, 0, 10'h005, 32'h0, 32'hDEADBEEF, "b2b_if5");
    t1 = last_rsp_t;
    access(1, 0, 10'h010, 32'h0, 32'h0C000001, "b2b_ld10");
    t2 = last_rsp_t;
    access(0, 0, 10'h3FF, 32'h0, 32'h00001234, "b2b_if3ff");
    t3 = last_rsp_t;
    chk("b2b:gap1", 32'(t2 - t1), 32'((L + 1) * 10));
    chk("b2b:gap2", 32'(t3 - t2), 32'((L + 1) * 10));

    // ---- contention: both channels held valid
    exp_g = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};   // 1 = D grant
    i_req_valid = 1'b1; i_req_addr = 10'h010;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 10'h005;
    n = 0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      #1;
      ir = i_req_ready; dr = d_req_ready;
      chk("cont:exclusive", 32'(ir & dr), 0);
      if (ir | dr) begin
        got[n] = dr;
        $display("txn cont grant %0d -> %s", n, dr ? "D" : "I");
        n++;
      end
      @(negedge clk);
    end
    chk("cont:grant_count", n, 10);
    for (int g = 0; g < 10; g++) chk($sformatf("cont:grant%0d", g), 32'(got[g]), 32'(exp_g[g]));
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    repeat (L + 1) @(negedge clk);
    chk("cont:drained", busy, 0);

    // ---- reset mid-access: store committed, response abandoned
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 10'h020; d_req_wdata = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    chk("midrst:busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst:busy", busy, 0);
    chk("midrst:d_ready", d_req_ready, 0);
    chk("midrst:d_rsp_valid", d_rsp_valid, 0);
    d_req_valid = 1'b0; d_req_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < L + 2; k++) begin
      #1;
      chk("midrst:no_stale_d", d_rsp_valid, 0);
      chk("midrst:no_stale_i", i_rsp_valid, 0);
      chk("midrst:idle", busy, 0);
      @(negedge clk);
    end
    access(1, 0, 10'h020, 32'h0, 32'h11111111, "ld20_after_rst");
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
